// File: rtl/mux2_stream_pkg.sv
// Shared types for the two-stream byte arbiter: grant states and select encoding.
package mux2_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} arb_state_t;
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/stream_mux2.sv
// Combinational WIDTH-bit 2:1 data mux; sel=1 picks a, sel=0 picks b.
module stream_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? a : b;
endmodule

// File: rtl/mux2_stream_arb.sv
// Round-robin arbiter for two valid/ready byte streams with a burst cap,
// feeding a one-entry registered output stage.
module mux2_stream_arb
  import mux2_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_t       state, state_nxt;
  logic             last, last_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic             space, acc_a, acc_b, accept;
  logic [WIDTH-1:0] mux_data;

  assign space   = !out_valid || out_ready;
  assign a_ready = (state == GNT_A) && space;
  assign b_ready = (state == GNT_B) && space;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign accept  = acc_a || acc_b;
  // In IDLE the select parks on whichever port was granted last.
  assign sel     = (state == GNT_A) || ((state == IDLE) && (last == SEL_A));
  assign busy    = (state != IDLE) || out_valid;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  stream_mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_data)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = accept ? cnt_inc : cnt;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = (last == SEL_A) ? GNT_B : GNT_A;
        else if (a_valid)       state_nxt = GNT_A;
        else if (b_valid)       state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!a_valid)                                      state_nxt = b_valid ? GNT_B : IDLE;
        else if (acc_a && (cnt_inc == CNT_MAX) && b_valid) state_nxt = GNT_B;
      end
      GNT_B: begin
        if (!b_valid)                                      state_nxt = a_valid ? GNT_A : IDLE;
        else if (acc_b && (cnt_inc == CNT_MAX) && a_valid) state_nxt = GNT_A;
      end
      default: state_nxt = IDLE;
    endcase
    // Any grant change restarts the burst; leaving a grant records who had it.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state == GNT_A) last_nxt = SEL_A;
      if (state == GNT_B) last_nxt = SEL_B;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      last  <= SEL_B;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux2_stream_arb.sv
// Bench for mux2_stream_arb: directed scenarios plus random traffic against a
// cycle-level reference model and per-port ordering scoreboard.
module tb_mux2_stream_arb;
  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [W-1:0] a_data, b_data, out_data;
  logic         a_valid, b_valid, a_ready, b_ready, sel, out_valid, out_ready, busy;

  mux2_stream_arb #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .aresetn(aresetn),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference: owner 0=none,1=A,2=B; last 1=A,2=B.
  int           m_own, m_last, m_cnt;
  bit           m_ov, m_acc_a, m_acc_b;
  logic [W-1:0] m_od;
  logic [W-1:0] qa[$], qb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_space();
    return !m_ov || out_ready;
  endfunction

  task automatic model_reset();
    m_own = 0; m_last = 2; m_cnt = 0; m_ov = 0; m_od = '0;
    m_acc_a = 0; m_acc_b = 0;
  endtask

  task automatic check_all();
    chk("a_ready",   a_ready,   (m_own == 1) && m_space());
    chk("b_ready",   b_ready,   (m_own == 2) && m_space());
    chk("sel",       sel,       (m_own == 1) || (m_own == 0 && m_last == 1));
    chk("out_valid", out_valid, m_ov);
    chk("out_data",  out_data,  m_od);
    chk("busy",      busy,      (m_own != 0) || m_ov);
  endtask

  task automatic model_step();
    bit acc, xv, yv;
    int nown, other, ncnt;
    m_acc_a = (m_own == 1) && m_space() && a_valid;
    m_acc_b = (m_own == 2) && m_space() && b_valid;
    acc = m_acc_a || m_acc_b;
    ncnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
    nown = m_own;
    if (m_own == 0) begin
      if (a_valid && b_valid) nown = (m_last == 1) ? 2 : 1;
      else if (a_valid)       nown = 1;
      else if (b_valid)       nown = 2;
    end else begin
      other = 3 - m_own;
      xv = (m_own == 1) ? a_valid : b_valid;
      yv = (m_own == 1) ? b_valid : a_valid;
      if (!xv) nown = yv ? other : 0;
      else if (acc && ncnt == MB && yv) nown = other;
    end
    if (acc) begin
      m_od = m_acc_a ? a_data : b_data;
      m_ov = 1;
    end else if (out_ready) m_ov = 0;
    if (nown != m_own) begin
      if (m_own != 0) m_last = m_own;
      m_cnt = 0;
    end else if (acc) m_cnt = ncnt;
    m_own = nown;
  endtask

  // One clock: check pre-edge outputs, advance model, check scoreboard after edge.
  task automatic step();
    bit ga, gb, gsel;
    logic [W-1:0] e;
    #1;
    check_all();
    ga = a_valid && a_ready; gb = b_valid && b_ready; gsel = sel;
    model_step();
    @(posedge clk); #1;
    if (ga || gb) begin
      if ((ga && qa.size() == 0) || (gb && qb.size() == 0)) chk("sb_empty", 1, 0);
      else begin
        e = ga ? qa.pop_front() : qb.pop_front();
        chk("sb_data", out_data, e);
        chk("sb_sel", gsel, ga);
      end
    end
  endtask

  task automatic offer_a(input logic [W-1:0] d);
    a_valid = 1; a_data = d; qa.push_back(d);
  endtask
  task automatic offer_b(input logic [W-1:0] d);
    b_valid = 1; b_data = d; qb.push_back(d);
  endtask

  task automatic do_reset();
    aresetn = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    a_valid = 0; b_valid = 0; out_ready = 1;
    qa.delete(); qb.delete();
    model_reset();
    @(posedge clk); #1;
    aresetn = 1;
    #1;
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    int beats;
    aresetn = 0; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; out_ready = 1;
    model_reset();
    #12;
    check_all();
    aresetn = 1;
    @(posedge clk); #1;

    // A only: AA, AB, AC back to back
    offer_a(8'hAA);
    step();
    chk("t2_sel", sel, 1);
    step();
    chk("t2_beat0", out_data, 8'hAA);
    offer_a(8'hAB);
    step();
    chk("t2_beat1", out_data, 8'hAB);
    offer_a(8'hAC);
    step();
    chk("t2_beat2", out_data, 8'hAC);
    a_valid = 0;
    step(); step();

    // Both valid continuously: bursts of MB, no bubbles
    do_reset();
    offer_a(8'hA0); offer_b(8'hB0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_acc_a) offer_a(a_data + 8'd1);
      if (m_acc_b) offer_b(b_data + 8'd1);
      if (c >= 1) begin
        chk("t3_no_bubble", out_valid, 1);
        chk("t3_order", out_data[7:4], (((c - 1) / MB) % 2 == 0) ? 4'hA : 4'hB);
      end
    end

    // Backpressure holds out_data, grant ready returns with out_ready
    do_reset();
    offer_b(8'hBB);
    step(); step();
    b_valid = 0;
    offer_a(8'h11);
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_hold_data", out_data, 8'hBB);
      chk("t4_a_ready", a_ready, 0);
    end
    out_ready = 1;
    #1 chk("t4_release", a_ready, 1);
    step();
    chk("t4_next", out_data, 8'h11);

    // Reset while a beat sits in the output register
    offer_a(8'h22);
    step();
    chk("t1_pre_valid", out_valid, 1);
    do_reset();

    // Burst cap with B idle: six A beats, no switch
    beats = 0;
    offer_a(8'h60);
    for (int c = 0; c < 9; c++) begin
      step();
      if (out_valid) beats++;
      if (m_acc_a) begin
        if (a_data < 8'h65) offer_a(a_data + 8'd1);
        else a_valid = 0;
      end
      if (c < 7) chk("t5_sel", sel, 1);
    end
    chk("t5_beats", beats, 6);

    // Random traffic
    do_reset();
    for (int c = 0; c < 200; c++) begin
      if (!a_valid || m_acc_a) begin
        a_valid = 0;
        if ($urandom_range(2) != 0) offer_a(W'($urandom));
      end
      if (!b_valid || m_acc_b) begin
        b_valid = 0;
        if ($urandom_range(2) != 0) offer_b(W'($urandom));
      end
      out_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
